// File: rtl/irq_ctrl.sv
// irq_ctrl: masked, prioritised interrupt controller with IACK/EOI handshake.
// Define IRQ_EDGE_EN for edge-triggered pending bits; the default build is level mode.
module irq_ctrl #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned ID_W       = 2,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             iack,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [31:0]      isr_addr,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] active;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic [ID_W-1:0]  irq_id_n;
    logic             irq_n;
    logic             busy_n;
    logic             mask_wr;
    logic             eoi_wr;
    logic             unused_wd;

    assign mask_wr   = we && (addr == 2'd0);
    assign eoi_wr    = we && (addr == 2'd2);
    assign active    = pend & mask;
    assign unused_wd = ^wd[31:N_SRC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            mask  <= '0;
        end else begin
            src_q <= irq_src;
            if (mask_wr)
                mask <= wd[N_SRC-1:0];
        end
    end

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0] src_qq;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_clr;
    logic             pend_wr;

    assign pend_wr = we && (addr == 2'd1);

    always_comb begin
        pend_set = src_q & ~src_qq;
        pend_clr = '0;
        if (pend_wr)
            pend_clr = wd[N_SRC-1:0];
        if (iack && (state == REQ))
            pend_clr = pend_clr | (N_SRC'(1) << irq_id);
    end

    // Set is OR-ed in after the clear so a new edge is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_qq <= '0;
            pend   <= '0;
        end else begin
            src_qq <= src_q;
            pend   <= (pend & ~pend_clr) | pend_set;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= '0;
        else
            pend <= src_q;
    end
`endif

    // Lowest index wins.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !win_found) begin
                win_id    = ID_W'(i);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        irq_id_n = irq_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n  = REQ;
                    irq_id_n = win_id;
                end
            end
            REQ: begin
                if (iack)
                    state_n = SERVICE;
            end
            SERVICE: begin
                if (eoi_wr)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        irq_n  = (state_n == REQ);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            irq_id <= '0;
            irq    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            irq_id <= irq_id_n;
            irq    <= irq_n;
            busy   <= busy_n;
        end
    end

    assign isr_addr = VEC_BASE + VEC_STRIDE * 32'(irq_id);

    always_comb begin
        rd = '0;
        case (addr)
            2'd0:    rd[N_SRC-1:0] = mask;
            2'd1:    rd[N_SRC-1:0] = pend;
            2'd3:    rd[ID_W+1:0]  = {irq_id, state};
            default: rd = '0;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the single-cycle MIPS core.
- Collects N_SRC external interrupt lines, masks and prioritises them, and raises one request to the CPU.
- Holds the winning source ID and its ISR address stable until the CPU executes IACK (opcode 6'b110000, decoded iack strobe).
- Blocks further requests until software writes End-Of-Interrupt (EOI) through a small memory-mapped register port.

Parameters:
- N_SRC, 4: number of interrupt sources (1..16).
- ID_W, 2: width of the source ID; 2**ID_W >= N_SRC required.
- VEC_BASE, 32'h0000_0180: ISR address of source 0.
- VEC_STRIDE, 32'h0000_0010: byte spacing between consecutive ISR entry points.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_src  in  N_SRC  device interrupt lines, active high.
- iack  in  1  one-cycle strobe from the main decoder when IACK executes.
- we  in  1  register write enable (from address decode).
- addr  in  2  register select: 0 MASK, 1 PEND, 2 EOI, 3 STAT.
- wd  in  32  write data.
- rd  out  32  read data, combinational from addr.
- irq  out  1  interrupt request to the CPU.
- irq_id  out  ID_W  ID of the requested or in-service source.
- isr_addr  out  32  VEC_BASE + irq_id*VEC_STRIDE, low 32 bits kept.
- busy  out  1  high in REQ and SERVICE.

Behaviour:
- Reset (asynchronous) values:
  - State IDLE.
  - irq=0, irq_id=0, busy=0.
  - pend=0, mask=0 (all sources disabled), source sample registers 0.
  - A reset mid-REQ or mid-SERVICE returns to IDLE immediately; no EOI is needed.
- Source sampling: irq_src is registered every cycle into src_q (ref. Optional Feature for how pend is derived).
- FSM, one transition per clk edge:
  - IDLE: if (pend & mask) != 0, go to REQ and latch irq_id = lowest-index set bit (index 0 has highest priority).
  - REQ:
    - irq=1. irq_id and isr_addr are frozen.
    - On iack=1: clear pend[irq_id] and go to SERVICE.
    - Masking or de-asserting the source while in REQ does not withdraw the request.
  - SERVICE:
    - irq=0, busy=1.
    - A write (we=1, addr=2) returns to IDLE; wd is ignored.
  - EOI writes in IDLE or REQ are ignored. iack outside REQ is ignored.
- Latency: source rises before edge k, so src_q is set at k, pend at k+1, the FSM enters REQ at k+2, and irq is high after edge k+2. After the EOI edge, a still-pending source re-enters REQ on the following edge.
- Simultaneous set and clear of the same pend bit: set wins.
- Registers:
  - MASK: R/W, low N_SRC bits, upper bits read 0.
  - PEND: read returns pend; write-1-to-clear, applied in edge mode only.
  - EOI: write-only, reads 0.
  - STAT: reads {irq_id in [ID_W+1:2], state in [1:0]}, with IDLE=0, REQ=1, SERVICE=2.
- irq, irq_id and busy are registered outputs. isr_addr is combinational from irq_id.

Optional Feature:
- Macro IRQ_EDGE_EN.
- Defined (edge mode):
  - A rising edge (src_q & ~src_qq) sets pend.
  - Bits clear on iack for irq_id or on a PEND W1C write.
  - A held-high line produces one interrupt.
- Undefined (level mode):
  - pend = src_q every cycle; the iack clear and W1C are no-ops.
  - The ISR must silence the device before EOI, otherwise the source re-requests.

Test Plan:
- Reset, MASK=4'b1111, pulse irq_src[2] high from cycle 0 → irq=1 at cycle 2, irq_id=2, isr_addr=32'h0000_01A0, STAT reads 0x9.
- In REQ, assert iack for 1 cycle, then write EOI → irq=0 and busy=1 until EOI, then IDLE with busy=0. In edge mode, a held src[2] does not re-trigger.
- irq_src=4'b1010 asserted together, MASK=4'b1111 → irq_id=1 first; after iack+EOI, irq_id=3 requested.
- MASK=4'b0000, src[0] high → irq stays 0 and PEND reads 1. Then write MASK=1 → irq=1 two cycles later.
- Assert rst during SERVICE → irq=0, busy=0, MASK and PEND read 0 in the same cycle, with no clock needed.
- Level mode: src[1] held high through iack+EOI → a second REQ for ID 1 is raised one cycle after EOI.
